fetch_unit_buffered: RTL

- Parametrised successor to the basic PC-increment fetch stage.
- Generates sequential fetch addresses with a configurable reset vector and step, and accepts branch/jump redirects.
- Issues requests to a pipelined instruction memory through a valid/ready handshake and holds in-order responses in a DEPTH-entry fetch buffer.
- Presents {instr, pc} to decode through a valid/ready handshake, so decode can stall fetch and execute can flush it.

---
 rtl/fetch_unit_buffered.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit_buffered.sv
// Buffered instruction fetch stage.
// Walks a sequential PC, issues requests to a pipelined instruction memory,
// collects in-order responses into a circular fetch buffer and hands
// {instr, pc} to decode under a valid/ready handshake. A redirect flushes the
// buffer and remembers how many in-flight responses must still be discarded.
module fetch_unit_buffered #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4,
    parameter int                DEPTH    = 4
) (
    input  logic               clk,
    input  logic               reset,
    output logic               req_valid,
    output logic [ADDR_W-1:0]  req_addr,
    input  logic               req_ready,
    input  logic               rsp_valid,
    input  logic [INSTR_W-1:0] rsp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               out_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Fetch PC and buffer bookkeeping
    logic [ADDR_W-1:0]  pc_reg;
    logic [PTR_W-1:0]   alloc_ptr_reg;
    logic [PTR_W-1:0]   fill_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    // Allocated entries still waiting for their response
    logic [CNT_W-1:0]   pend_reg;
    // Responses still in flight that belong to flushed requests
    logic [CNT_W-1:0]   drop_reg;

    // Buffer storage
    logic [ADDR_W-1:0]  entry_pc    [DEPTH];
    logic [INSTR_W-1:0] entry_instr [DEPTH];
    logic               filled_reg  [DEPTH];

    logic issue;
    logic accept_rsp;
    logic drop_rsp;
    logic pop;

    // Handshake decode; reset forces both valids low while it is held
    always_comb begin
        req_valid  = reset && !redirect_valid && (count_reg < CNT_W'(DEPTH));
        out_valid  = reset && !redirect_valid && filled_reg[rd_ptr_reg] && (count_reg != '0);
        issue      = req_valid && req_ready;
        pop        = out_valid && out_ready;
        accept_rsp = rsp_valid && !redirect_valid && (drop_reg == '0) && (pend_reg != '0);
        drop_rsp   = rsp_valid && !redirect_valid && (drop_reg != '0);
        req_addr   = pc_reg;
        out_instr  = entry_instr[rd_ptr_reg];
        out_pc     = entry_pc[rd_ptr_reg];
    end

    // PC, pointers and counters; a redirect overrides every other update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg        <= RESET_PC;
            alloc_ptr_reg <= '0;
            fill_ptr_reg  <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            pend_reg      <= '0;
            drop_reg      <= '0;
        end else if (redirect_valid) begin
            pc_reg        <= redirect_pc;
            alloc_ptr_reg <= '0;
            fill_ptr_reg  <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            pend_reg      <= '0;
            // Every unfilled request is now stale; a response landing in this
            // very cycle is one of them and is already consumed here.
            drop_reg      <= drop_reg + pend_reg - CNT_W'(rsp_valid);
        end else begin
            if (issue) begin
                pc_reg        <= pc_reg + ADDR_W'(PC_STEP);
                alloc_ptr_reg <= alloc_ptr_reg + PTR_W'(1);
            end
            if (accept_rsp) begin
                fill_ptr_reg <= fill_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (drop_rsp) begin
                drop_reg <= drop_reg - CNT_W'(1);
            end
            count_reg <= count_reg + CNT_W'(issue) - CNT_W'(pop);
            pend_reg  <= pend_reg + CNT_W'(issue) - CNT_W'(accept_rsp);
        end
    end

    // Per-entry filled flags; fill and pop never target the same entry
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_flag
            // Set on accepted response, cleared on allocate, pop or flush
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    filled_reg[gi] <= 1'b0;
                end else if (redirect_valid) begin
                    filled_reg[gi] <= 1'b0;
                end else if (accept_rsp && (fill_ptr_reg == PTR_W'(gi))) begin
                    filled_reg[gi] <= 1'b1;
                end else if ((pop && (rd_ptr_reg == PTR_W'(gi))) ||
                             (issue && (alloc_ptr_reg == PTR_W'(gi)))) begin
                    filled_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // Entry payloads need no reset: they are only read once marked filled
    always_ff @(posedge clk) begin
        if (issue) begin
            entry_pc[alloc_ptr_reg] <= pc_reg;
        end
        if (accept_rsp) begin
            entry_instr[fill_ptr_reg] <= rsp_data;
        end
    end

    // A response with nothing waiting for it means the memory broke protocol
    always @(posedge clk) begin
        if (reset && rsp_valid) begin
            assert ((drop_reg != '0) || (pend_reg != '0));
        end
    end

endmodule
